key_debounce_ch: RTL and testbench
==================================

// Module: key_debounce_ch
// PURPOSE
//  Parametrised N-channel push-button conditioner; successor to the fixed 4-key debouncer.
//  Each channel runs its own synchroniser, debounce counter and hold timer, so bounce on
//  one key never delays or corrupts another. Outputs debounced level, press/release strobes,
//  and long-press plus auto-repeat strobes. Sits between board keys and UI/control FSMs.
// PARAMETERS
//  NUM_KEYS        4          number of independent key channels (>=1)
//  ACTIVE_LOW      1          1: key_in low = pressed; 0: key_in high = pressed
//  DEBOUNCE_CYCLES 1_000_000  cycles a new level must be stable to be accepted (20 ms @ 50 MHz, >=2)
//  LONG_CYCLES     50_000_000 cycles held (after press strobe) before key_long (1 s @ 50 MHz, >=1)
//  REPEAT_CYCLES   10_000_000 auto-repeat period after key_long; 0 disables key_repeat
// PORTS
//  sys_clk      in   1         system clock, 50 MHz
//  sys_rstn     in   1         async active-low reset
//  key_in       in   NUM_KEYS  raw asynchronous key pins
//  key_state    out  NUM_KEYS  debounced level, 1 = pressed (polarity normalised)
//  key_press    out  NUM_KEYS  1-cycle strobe when key_state goes 0->1
//  key_release  out  NUM_KEYS  1-cycle strobe when key_state goes 1->0
//  key_long     out  NUM_KEYS  1-cycle strobe, once per press, after LONG_CYCLES held
//  key_repeat   out  NUM_KEYS  1-cycle strobe every REPEAT_CYCLES after key_long while held
//  key_any      out  1         OR of key_state, registered same cycle as key_state
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops = released level, all counters 0,
//   all outputs 0. No strobes during or on the first cycle after reset.
//  Per channel, all logic identical and independent:
//  - 2-flop synchroniser, then polarity normalise -> key_sync (1 = pressed).
//  - Debounce: key_sync==key_state -> deb_cnt<=0. Else deb_cnt increments; when
//    deb_cnt==DEBOUNCE_CYCLES-1 and still differing: key_state toggles, deb_cnt<=0,
//    key_press or key_release asserted for exactly that one cycle.
//  - Latency: key_state changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge
//    that first samples the new level. Any glitch back to key_state level restarts the count.
//  - Hold FSM, states IDLE, HELD, LONG:
//    IDLE -> HELD on key_press (hold_cnt<=0).
//    HELD: hold_cnt++; at hold_cnt==LONG_CYCLES-1 -> LONG, pulse key_long, rep_cnt<=0.
//    LONG: if REPEAT_CYCLES!=0, rep_cnt++; at REPEAT_CYCLES-1 pulse key_repeat, rep_cnt<=0.
//    Any state -> IDLE on key_release (same cycle as release strobe); counters cleared.
//    key_long/key_repeat never coincide with key_release; a release takes priority.
//  - Counter widths: $clog2 of the respective parameter; no wrap past terminal values.
//  - Press and release strobes are mutually exclusive per channel; different channels may
//    strobe in the same cycle.
//  - Reset mid-operation: all state lost immediately; a key still held at reset release
//    is re-detected as a fresh press after the full debounce latency.
//  - All outputs registered; no combinational path from key_in to any output.
// TESTING  (NUM_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=16)
//  1 Clean press key_in[0] 1->0, held -> key_state[0]=1 and key_press[0]=1 for one cycle on
//    the 10th edge; key_release stays 0; other channels stay 0.
//  2 Bounce key_in[1]: low 5 cycles, high 1 cycle, then low -> no strobe until 8 stable
//    cycles after the last bounce; exactly one key_press[1].
//  3 Hold key 2 for 100 cycles after key_press -> key_long[2] at +32 cycles, key_repeat[2] at
//    +48, +64, +80, +96; release -> one key_release, no further long/repeat.
//  4 Keys 0 and 3 pressed on the same edge -> key_press=4'b1001 on one cycle; key_any=1;
//    release key 3 only -> key_release=4'b1000, key_any stays 1.
//  5 Assert sys_rstn low mid-hold (key 0 held, HELD state) -> all outputs 0 immediately;
//    after release, key_press[0] after 10 edges, key_long[0] 32 cycles later.
//  6 REPEAT_CYCLES=0 rerun of 3 -> key_long once, key_repeat never asserts.

Source files
------------

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: N-channel key synchroniser/debouncer with press, release, long-press and auto-repeat strobes
module key_debounce_ch #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                key_any
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = LONG_CYCLES > 1 ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DW-1:0] D_TOP = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_TOP = LW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] R_TOP = RW'(REPEAT_CYCLES - 1);
  localparam logic REL = ACTIVE_LOW != 0;
  localparam logic [1:0] IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2;
  logic [NUM_KEYS-1:0] state_nxt;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    logic s1, s2, sync, toggle, st, pr, rl, lg, rp;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic [1:0] fsm;
    assign sync = s2 ^ REL;
    assign toggle = sync != st && deb_cnt == D_TOP;
    assign state_nxt[k] = st ^ toggle;
    assign key_state[k] = st;
    assign key_press[k] = pr;
    assign key_release[k] = rl;
    assign key_long[k] = lg;
    assign key_repeat[k] = rp;
    always_ff @(posedge sys_clk or negedge sys_rstn)
      if (!sys_rstn) begin
        s1 <= REL;
        s2 <= REL;
        deb_cnt <= '0;
        hold_cnt <= '0;
        rep_cnt <= '0;
        fsm <= IDLE;
        st <= 1'b0;
        pr <= 1'b0;
        rl <= 1'b0;
        lg <= 1'b0;
        rp <= 1'b0;
      end else begin
        s1 <= key_in[k];
        s2 <= s1;
        deb_cnt <= (sync == st || toggle) ? '0 : deb_cnt + 1'b1;
        st <= state_nxt[k];
        pr <= toggle && !st;
        rl <= toggle && st;
        lg <= 1'b0;
        rp <= 1'b0;
        // a debounced edge overrides the hold timers, so release always wins
        if (toggle) begin
          fsm <= st ? IDLE : HELD;
          hold_cnt <= '0;
          rep_cnt <= '0;
        end else if (fsm == HELD) begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == L_TOP) begin
            fsm <= LONG;
            lg <= 1'b1;
            hold_cnt <= '0;
            rep_cnt <= '0;
          end
        end else if (fsm == LONG && REPEAT_CYCLES != 0) begin
          rep_cnt <= rep_cnt == R_TOP ? '0 : rep_cnt + 1'b1;
          rp <= rep_cnt == R_TOP;
        end
      end
  end
  always_ff @(posedge sys_clk or negedge sys_rstn)
    if (!sys_rstn) key_any <= 1'b0;
    else key_any <= |state_nxt;
endmodule

// File: tb/tb_key_debounce_ch.sv
// tb_key_debounce_ch: directed scoreboard bench; dut_a repeats every 16 cycles, dut_b has repeat disabled
module tb_key_debounce_ch;
  typedef struct {
    int cyc;
    logic [3:0] p, r, l, t, s;
    logic a;
  } ev_t;
  logic sys_clk, sys_rstn;
  logic [3:0] key_in;
  logic [3:0] a_s, a_p, a_r, a_l, a_t, b_s, b_p, b_r, b_l, b_t;
  logic a_any, b_any;
  int cyc = 0, checks = 0, errors = 0;
  ev_t qa[$], qb[$];
  key_debounce_ch #(.NUM_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16)) dut_a (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .key_in(key_in), .key_state(a_s), .key_press(a_p),
    .key_release(a_r), .key_long(a_l), .key_repeat(a_t), .key_any(a_any));
  key_debounce_ch #(.NUM_KEYS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(0)) dut_b (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn), .key_in(key_in), .key_state(b_s), .key_press(b_p),
    .key_release(b_r), .key_long(b_l), .key_repeat(b_t), .key_any(b_any));
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  task automatic exp(input bit to_b, input int c, input logic [3:0] p, r, l, t, s, input logic a);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.l = l; e.t = t; e.s = s; e.a = a;
    qa.push_back(e);
    if (to_b) qb.push_back(e);
  endtask
  task automatic chk(input string nm, input ev_t e, input logic [3:0] p, r, l, t, s, input logic a);
    checks++;
    if (cyc != e.cyc || {p, r, l, t, s, a} != {e.p, e.r, e.l, e.t, e.s, e.a}) begin
      errors++;
      $display("FAIL %s event: got cyc=%0d press=%b rel=%b long=%b rep=%b state=%b any=%b, want cyc=%0d press=%b rel=%b long=%b rep=%b state=%b any=%b",
        nm, cyc, p, r, l, t, s, a, e.cyc, e.p, e.r, e.l, e.t, e.s, e.a);
    end
  endtask
  task automatic unexpected(input string nm, input logic [3:0] p, r, l, t);
    checks++;
    errors++;
    $display("FAIL %s unexpected strobe at cyc=%0d: press=%b rel=%b long=%b rep=%b, want none", nm, cyc, p, r, l, t);
  endtask
  always @(negedge sys_clk) if (sys_rstn) begin
    if (|{a_p, a_r, a_l, a_t}) begin
      if (qa.size() == 0) unexpected("dut_a", a_p, a_r, a_l, a_t);
      else chk("dut_a", qa.pop_front(), a_p, a_r, a_l, a_t, a_s, a_any);
    end
    if (|{b_p, b_r, b_l, b_t}) begin
      if (qb.size() == 0) unexpected("dut_b", b_p, b_r, b_l, b_t);
      else chk("dut_b", qb.pop_front(), b_p, b_r, b_l, b_t, b_s, b_any);
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic chk_zero(input string nm);
    checks += 2;
    if ({a_s, a_p, a_r, a_l, a_t, a_any} != 0) begin
      errors++;
      $display("FAIL %s dut_a outputs in reset: got %h, want 0", nm, {a_s, a_p, a_r, a_l, a_t, a_any});
    end
    if ({b_s, b_p, b_r, b_l, b_t, b_any} != 0) begin
      errors++;
      $display("FAIL %s dut_b outputs in reset: got %h, want 0", nm, {b_s, b_p, b_r, b_l, b_t, b_any});
    end
  endtask
  initial begin
    int c;
    sys_rstn = 1'b1;
    key_in = 4'hf;
    #2 sys_rstn = 1'b0;
    step(1);
    #1 chk_zero("por");
    step(3);
    sys_rstn = 1'b1;
    step(3);
    // clean press then release of key 0 before long-press
    c = cyc;
    key_in[0] = 1'b0;
    exp(1, c + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    step(20);
    key_in[0] = 1'b1;
    exp(1, c + 30, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(15);
    // bounce on key 1: the count restarts after the last glitch
    c = cyc;
    key_in[1] = 1'b0;
    step(5);
    key_in[1] = 1'b1;
    step(1);
    key_in[1] = 1'b0;
    exp(1, c + 16, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1);
    step(20);
    key_in[1] = 1'b1;
    exp(1, c + 36, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(15);
    // long hold of key 2: long at +32, repeats at +48..+96 on dut_a only
    c = cyc;
    key_in[2] = 1'b0;
    exp(1, c + 10, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    exp(1, c + 42, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    for (int i = 1; i <= 4; i++) exp(0, c + 42 + 16 * i, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b1);
    step(110);
    key_in[2] = 1'b1;
    exp(1, c + 120, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(15);
    // keys 0 and 3 together, release 3 first
    c = cyc;
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    exp(1, c + 10, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 1'b1);
    step(12);
    key_in[3] = 1'b1;
    exp(1, c + 22, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    exp(1, c + 42, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    step(33);
    key_in[0] = 1'b1;
    exp(1, c + 55, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(15);
    // reset while key 0 is held: fresh press after reset release
    c = cyc;
    key_in[0] = 1'b0;
    exp(1, c + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    step(20);
    sys_rstn = 1'b0;
    #1 chk_zero("mid_hold");
    step(3);
    sys_rstn = 1'b1;
    c = cyc;
    exp(1, c + 10, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    exp(1, c + 42, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    step(45);
    key_in[0] = 1'b1;
    exp(1, c + 55, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(20);
    checks += 2;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL dut_a missing events: got %0d pending, want 0", qa.size());
    end
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL dut_b missing events: got %0d pending, want 0", qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
